updn_counter: RTL and testbench
===============================

UPDN_COUNTER -- requirements
Module: updn_counter

Interface
REQ-001 Parameter WIDTH, default 16: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2^WIDTH-1: terminal count value, legal range 1..2^WIDTH-1.
REQ-003 Parameter SAT, default 0: 0 selects wrap mode; 1 selects saturate mode.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  local count enable.
REQ-007 ci  input  1  cascade carry-in; tie to 1 on the least significant stage.
REQ-008 s  input  1  direction: 1 counts up, 0 counts down.
REQ-009 ld  input  1  synchronous load strobe.
REQ-010 d  input  WIDTH  load value.
REQ-011 clr  input  1  synchronous clear of ovf.
REQ-012 cnt  output  WIDTH  registered count.
REQ-013 tc  output  1  combinational terminal flag: (s & cnt==MAX) | (~s & cnt==0).
REQ-014 rc  output  1  combinational cascade carry-out: en & ci & tc.
REQ-015 ovf  output  1  registered sticky flag: a step was attempted at the terminal value.

Function
REQ-016 A step occurs on a rising clk edge when en=1, ci=1 and ld=0.
REQ-017 Step in up mode, cnt<MAX: cnt <= cnt+1.
REQ-018 Step in down mode, cnt>0: cnt <= cnt-1.
REQ-019 Wrap mode (SAT=0), boundary steps: up at MAX gives cnt <= 0; down at 0 gives cnt <= MAX.
REQ-020 Saturate mode (SAT=1), boundary steps: up at MAX and down at 0 both hold cnt.
REQ-021 A step taken while tc=1 sets ovf <= 1, in either mode.
REQ-022 Load priority: ld=1 loads cnt <= d regardless of en, ci and s, and overrides any step.
REQ-023 Load clamp: if d>MAX, cnt <= MAX.
REQ-024 A load never sets ovf.
REQ-025 clr=1 clears ovf <= 0 on the next edge.
REQ-026 If clr=1 and an ovf-setting step occur in the same cycle, ovf ends at 1 (set wins).
REQ-027 With no step, no load and no clr, cnt and ovf hold their values.
REQ-028 tc and rc follow s and cnt combinationally, with zero-cycle latency; a change on s updates them in the same cycle.
REQ-029 Cascade: stage N's rc drives stage N+1's ci; N stages of WIDTH bits with MAX=2^WIDTH-1 SHALL count identically to one N*WIDTH-bit counter.
REQ-030 cnt outside 0..MAX is unreachable after reset or load; no behaviour is defined for it.
REQ-031 Arithmetic is modulo 2^WIDTH internally; no carry beyond WIDTH bits is observable except through tc and rc.

Reset
REQ-032 rst_n=0 forces cnt=0 and ovf=0 immediately, without waiting for clk.
REQ-033 While rst_n=0: tc reflects cnt=0 (tc=1 when s=0), and en, ci, ld and clr are ignored.
REQ-034 Reset asserted mid-count aborts the pending step; on the first edge after rst_n rises, normal operation resumes from cnt=0.

Verification (WIDTH=4, MAX=9 unless stated)
REQ-035 Wrap up: SAT=0, s=1, en=ci=1 from cnt=0 for 12 cycles -> sequence 1..9,0,1,2; tc=rc=1 only while cnt=9; ovf=1 from the edge after 9->0.
REQ-036 Saturate down: SAT=1, ld d=2, then s=0 stepping 5 cycles -> cnt 1,0,0,0,0; ovf=1 after the first step at 0; clr pulse with en=0 -> ovf=0.
REQ-037 Load priority and clamp: ld=1 with d=4'hF while en=ci=1 -> cnt=9, ovf unchanged; ld=1 with d=3 and s=0 -> cnt=3.
REQ-038 Simultaneous clr and overflow: cnt=9, s=1, en=ci=1, clr=1 -> cnt=0 and ovf=1.
REQ-039 Cascade: two stages, WIDTH=4, MAX=15, up from 8'hFE for 3 cycles -> {hi,lo} = 8'hFF, 8'h00, 8'h01; hi.rc=1 only at 8'hFF; then s=0 from 8'h00 -> 8'hFF.
REQ-040 Async reset: assert rst_n=0 mid-cycle at cnt=7, ovf=1 -> cnt=0 and ovf=0 before the next edge; release -> stepping resumes 1,2,...

Source files
------------

// File: rtl/updn_counter_if.sv
// Control/status bundle for one updn_counter stage.
// master drives the controls; slave is the counter side.
interface updn_counter_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             ci;
  logic             s;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             clr;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             rc;
  logic             ovf;

  modport master (output en, ci, s, ld, d, clr, input  cnt, tc, rc, ovf);
  modport slave  (input  en, ci, s, ld, d, clr, output cnt, tc, rc, ovf);
endinterface

// File: rtl/updn_counter.sv
// Cascadable up/down counter with programmable terminal count,
// wrap or saturate at the boundary, and a sticky overflow flag.
module updn_counter #(
  parameter int              WIDTH = 16,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SAT   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  updn_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = MAX[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_nxt;
  logic             ovf_q;
  logic             at_tc, step;

  assign at_tc = bus.s ? (cnt_q == MAXV) : (cnt_q == '0);
  assign step  = bus.en & bus.ci & ~bus.ld;

  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.ld) begin
      cnt_nxt = (bus.d > MAXV) ? MAXV : bus.d;
    end else if (step) begin
      // Boundary steps wrap to the opposite end, or hold when saturating.
      if (at_tc) begin
        if (!SAT) cnt_nxt = bus.s ? '0 : MAXV;
      end else begin
        cnt_nxt = bus.s ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      // set beats clear when both happen in one cycle
      if (step & at_tc)  ovf_q <= 1'b1;
      else if (bus.clr)  ovf_q <= 1'b0;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = at_tc;
  assign bus.rc  = bus.en & bus.ci & at_tc;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_updn_counter.sv
// Bench for updn_counter: wrap and saturate stages (WIDTH=4, MAX=9) plus a
// two-stage 8-bit cascade, checked against an arithmetic reference model.
module tb_updn_counter;
  localparam int unsigned MX = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  updn_counter_if #(.WIDTH(4)) if_w ();
  updn_counter_if #(.WIDTH(4)) if_s ();
  updn_counter_if #(.WIDTH(4)) if_lo ();
  updn_counter_if #(.WIDTH(4)) if_hi ();

  updn_counter #(.WIDTH(4), .MAX(9),  .SAT(1'b0)) u_w  (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));
  updn_counter #(.WIDTH(4), .MAX(9),  .SAT(1'b1)) u_s  (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  updn_counter #(.WIDTH(4), .MAX(15), .SAT(1'b0)) u_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo.slave));
  updn_counter #(.WIDTH(4), .MAX(15), .SAT(1'b0)) u_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi.slave));

  logic       c_en, c_s, c_ld, c_clr;
  logic [7:0] c_d;

  assign if_lo.en  = c_en;
  assign if_lo.ci  = 1'b1;
  assign if_lo.s   = c_s;
  assign if_lo.ld  = c_ld;
  assign if_lo.d   = c_d[3:0];
  assign if_lo.clr = c_clr;
  assign if_hi.en  = c_en;
  assign if_hi.ci  = if_lo.rc;
  assign if_hi.s   = c_s;
  assign if_hi.ld  = c_ld;
  assign if_hi.d   = c_d[7:4];
  assign if_hi.clr = c_clr;

  always #5 clk = ~clk;

  // reference state
  int unsigned mw, ms, mc;
  bit          mwo, mso;

  function automatic bit tcx(int unsigned c, bit s);
    return s ? (c == MX) : (c == 0);
  endfunction

  function automatic int unsigned mnext(int unsigned c, bit sat, bit en, bit ci, bit s, bit ld, int unsigned d);
    if (ld)          return (d > MX) ? MX : d;
    if (!(en && ci)) return c;
    if (s) return sat ? ((c < MX) ? c + 1 : c) : (c + 1) % (MX + 1);
    return sat ? ((c > 0) ? c - 1 : 0) : (c + MX) % (MX + 1);
  endfunction

  function automatic bit movf(int unsigned c, bit o, bit en, bit ci, bit s, bit ld, bit clr);
    if (!ld && en && ci && tcx(c, s)) return 1'b1;
    if (clr) return 1'b0;
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational flags, advance the model, check state.
  task automatic cyc();
    int unsigned nw, ns, nc;
    bit          nwo, nso;
    #1;
    chk("w_tc", 32'(if_w.tc), 32'(tcx(mw, if_w.s)));
    chk("w_rc", 32'(if_w.rc), 32'(if_w.en & if_w.ci & tcx(mw, if_w.s)));
    chk("s_tc", 32'(if_s.tc), 32'(tcx(ms, if_s.s)));
    chk("s_rc", 32'(if_s.rc), 32'(if_s.en & if_s.ci & tcx(ms, if_s.s)));
    chk("c_rc", 32'(if_hi.rc), 32'(c_en && (c_s ? (mc == 255) : (mc == 0))));
    nw  = mnext(mw, 1'b0, if_w.en, if_w.ci, if_w.s, if_w.ld, if_w.d);
    nwo = movf (mw, mwo,  if_w.en, if_w.ci, if_w.s, if_w.ld, if_w.clr);
    ns  = mnext(ms, 1'b1, if_s.en, if_s.ci, if_s.s, if_s.ld, if_s.d);
    nso = movf (ms, mso,  if_s.en, if_s.ci, if_s.s, if_s.ld, if_s.clr);
    if (c_ld)      nc = c_d;
    else if (c_en) nc = c_s ? (mc + 1) % 256 : (mc + 255) % 256;
    else           nc = mc;
    @(posedge clk);
    #1;
    mw = nw; mwo = nwo; ms = ns; mso = nso; mc = nc;
    chk("w_cnt", 32'(if_w.cnt), mw);
    chk("w_ovf", 32'(if_w.ovf), 32'(mwo));
    chk("s_cnt", 32'(if_s.cnt), ms);
    chk("s_ovf", 32'(if_s.ovf), 32'(mso));
    chk("c_cnt", 32'({if_hi.cnt, if_lo.cnt}), mc);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned seq035 [12];
    int unsigned cnt036 [5];
    int unsigned ovf036 [5];
    logic [7:0]  c039   [3];
    seq035 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    cnt036 = '{1, 0, 0, 0, 0};
    ovf036 = '{0, 0, 1, 1, 1};
    c039   = '{8'hFF, 8'h00, 8'h01};

    // reset with active-looking controls that must be ignored
    rst_n = 1'b0;
    if_w.en = 1; if_w.ci = 1; if_w.s = 0; if_w.ld = 1; if_w.d = 4'd5; if_w.clr = 0;
    if_s.en = 0; if_s.ci = 1; if_s.s = 0; if_s.ld = 0; if_s.d = 4'd0; if_s.clr = 0;
    c_en = 0; c_s = 1; c_ld = 0; c_d = 8'h00; c_clr = 0;
    mw = 0; mwo = 0; ms = 0; mso = 0; mc = 0;
    #1;
    chk("rst_cnt", 32'(if_w.cnt), 0);
    chk("rst_ovf", 32'(if_w.ovf), 0);
    chk("rst_tc",  32'(if_w.tc),  1);
    @(posedge clk); #1;
    chk("rst_hold", 32'(if_w.cnt), 0);
    if_w.ld = 0; if_w.en = 0;
    rst_n = 1'b1;

    // wrap up through 9 -> 0
    if_w.s = 1; if_w.en = 1; if_w.ci = 1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("w035_seq", 32'(if_w.cnt), seq035[i]);
    end
    chk("w035_ovf", 32'(if_w.ovf), 1);
    if_w.en = 0;

    // saturate down from 2
    if_s.ld = 1; if_s.d = 4'd2; cyc();
    if_s.ld = 0; if_s.s = 0; if_s.en = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s036_cnt", 32'(if_s.cnt), cnt036[i]);
      chk("s036_ovf", 32'(if_s.ovf), ovf036[i]);
    end
    if_s.en = 0; if_s.clr = 1; cyc();
    chk("s036_clr", 32'(if_s.ovf), 0);
    if_s.clr = 0;

    // load priority and clamp
    if_w.en = 1; if_w.ci = 1; if_w.s = 1; if_w.ld = 1; if_w.d = 4'hF; cyc();
    chk("w037_clamp", 32'(if_w.cnt), 9);
    chk("w037_ovf",   32'(if_w.ovf), 1);
    if_w.d = 4'd3; if_w.s = 0; cyc();
    chk("w037_ld3", 32'(if_w.cnt), 3);

    // clear and overflow in the same cycle
    if_w.ld = 0; if_w.en = 0; if_w.clr = 1; cyc();
    if_w.clr = 0; if_w.ld = 1; if_w.d = 4'd9; cyc();
    if_w.ld = 0; if_w.s = 1; if_w.en = 1; if_w.clr = 1; cyc();
    chk("w038_cnt", 32'(if_w.cnt), 0);
    chk("w038_ovf", 32'(if_w.ovf), 1);
    if_w.clr = 0;

    // asynchronous reset mid-cycle at cnt=7, ovf=1
    if_w.ld = 1; if_w.d = 4'd7; cyc();
    if_w.ld = 0; if_w.en = 0;
    chk("w040_pre_cnt", 32'(if_w.cnt), 7);
    chk("w040_pre_ovf", 32'(if_w.ovf), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("w040_cnt", 32'(if_w.cnt), 0);
    chk("w040_ovf", 32'(if_w.ovf), 0);
    mw = 0; mwo = 0; ms = 0; mso = 0; mc = 0;
    #1 rst_n = 1'b1;
    if_w.en = 1; if_w.s = 1; if_w.ci = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("w040_resume", 32'(if_w.cnt), i);
    end
    if_w.en = 0;

    // two-stage cascade as an 8-bit counter
    c_ld = 1; c_d = 8'hFE; cyc();
    c_ld = 0; c_en = 1; c_s = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("c039_up", 32'({if_hi.cnt, if_lo.cnt}), 32'(c039[i]));
    end
    c_ld = 1; c_d = 8'h00; cyc();
    c_ld = 0; c_s = 0; cyc();
    chk("c039_dn", 32'({if_hi.cnt, if_lo.cnt}), 32'hFF);

    // random traffic on all stages
    for (int i = 0; i < 400; i++) begin
      if_w.en  = ($urandom_range(0, 3) != 0);
      if_w.ci  = ($urandom_range(0, 3) != 0);
      if_w.s   = ($urandom_range(0, 9) < 7) ? if_w.s : ~if_w.s;
      if_w.ld  = ($urandom_range(0, 7) == 0);
      if_w.d   = 4'($urandom);
      if_w.clr = ($urandom_range(0, 7) == 0);
      if_s.en  = ($urandom_range(0, 3) != 0);
      if_s.ci  = ($urandom_range(0, 3) != 0);
      if_s.s   = ($urandom_range(0, 9) < 7) ? if_s.s : ~if_s.s;
      if_s.ld  = ($urandom_range(0, 7) == 0);
      if_s.d   = 4'($urandom);
      if_s.clr = ($urandom_range(0, 7) == 0);
      c_en     = ($urandom_range(0, 3) != 0);
      c_s      = ($urandom_range(0, 9) < 7) ? c_s : ~c_s;
      c_ld     = ($urandom_range(0, 15) == 0);
      c_d      = 8'($urandom);
      c_clr    = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
